// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forwarding-select encoding, scoreboard entry layout and stage indices.
package hazard_ctrl_pkg;

    localparam int REG_AW_DEF = 5;

    // Scoreboard depth and stage slots, youngest first.
    localparam int SB_DEPTH = 3;
    localparam int SB_EX    = 0;
    localparam int SB_MEM   = 1;
    localparam int SB_WB    = 2;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_DEF-1:0] rd;
        logic                  we;
        logic                  is_load;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = '0;

    // Operand select for one source: the youngest in-flight producer wins,
    // and a producer already in WB is left to the regfile bypass.
    function automatic fwd_sel_e fwd_pick(input logic use_src,
                                          input logic hit_ex,
                                          input logic hit_mem);
        if (!use_src) return FWD_RF;
        if (hit_ex)   return FWD_EXMEM;
        if (hit_mem)  return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID-stage instruction info, redirect input and the hazard
// controller's stall/flush/forward outputs.
interface hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) ();
    import hazard_ctrl_pkg::*;

    logic              id_valid_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_rd_we_i;
    logic              id_is_load_i;
    logic              ex_redirect_i;

    logic              stall_if_o;
    logic              stall_id_o;
    logic              flush_if_o;
    logic              flush_id_o;
    logic              bubble_ex_o;
    fwd_sel_e          fwd_rs1_o;
    fwd_sel_e          fwd_rs2_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    // Pipeline side: supplies the ID instruction, consumes hazard decisions.
    modport master (
        output id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_rd_we_i, id_is_load_i, ex_redirect_i,
        input  stall_if_o, stall_id_o, flush_if_o, flush_id_o, bubble_ex_o,
               fwd_rs1_o, fwd_rs2_o, stall_cnt_o
    );

    // Hazard controller side.
    modport slave (
        input  id_valid_i, id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
               id_rd_i, id_rd_we_i, id_is_load_i, ex_redirect_i,
        output stall_if_o, stall_id_o, flush_if_o, flush_id_o, bubble_ex_o,
               fwd_rs1_o, fwd_rs2_o, stall_cnt_o
    );

endinterface

// File: rtl/hazard_match.sv
// Register-dependency compare of one source index against one scoreboard
// entry. x0 is hardwired zero, so it never creates a dependency.
module hazard_match
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_AW_DEF-1:0] src_i,
    input  sb_entry_t             entry_i,
    output logic                  hit_o
);

    assign hit_o = entry_i.valid && entry_i.we &&
                   (entry_i.rd == src_i) && (src_i != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// In-order pipeline hazard controller: load-use stall, redirect flush,
// EX operand forwarding selects and a saturating load-use stall counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    // Scoreboard entries are laid out with a fixed index width.
    if (REG_AW != REG_AW_DEF) begin : g_aw_check
        $error("hazard_ctrl: REG_AW must equal REG_AW_DEF");
    end

    sb_entry_t        sb_q [SB_DEPTH];
    sb_entry_t        sb_d [SB_DEPTH];
    fwd_sel_e         fwd_rs1_q, fwd_rs1_d;
    fwd_sel_e         fwd_rs2_q, fwd_rs2_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic rs1_hit_ex, rs2_hit_ex, rs1_hit_mem, rs2_hit_mem;
    logic luse;
    logic stall, flush, bubble;

    hazard_match u_rs1_ex  (.src_i(hz.id_rs1_i), .entry_i(sb_q[SB_EX]),  .hit_o(rs1_hit_ex));
    hazard_match u_rs2_ex  (.src_i(hz.id_rs2_i), .entry_i(sb_q[SB_EX]),  .hit_o(rs2_hit_ex));
    hazard_match u_rs1_mem (.src_i(hz.id_rs1_i), .entry_i(sb_q[SB_MEM]), .hit_o(rs1_hit_mem));
    hazard_match u_rs2_mem (.src_i(hz.id_rs2_i), .entry_i(sb_q[SB_MEM]), .hit_o(rs2_hit_mem));

    // A load in EX cannot forward in time to the ID instruction that reads it.
    assign luse = hz.id_valid_i && sb_q[SB_EX].is_load &&
                  ((hz.id_use_rs1_i && rs1_hit_ex) || (hz.id_use_rs2_i && rs2_hit_ex));

    // Pipeline control; a redirect squashes the stalled instruction anyway,
    // so it overrides a simultaneous load-use stall.
    always_comb begin
        stall  = 1'b0;
        flush  = 1'b0;
        bubble = 1'b0;
        if (hz.ex_redirect_i) begin
            flush  = 1'b1;
            bubble = 1'b1;
        end else if (luse) begin
            stall  = 1'b1;
            bubble = 1'b1;
        end
    end

    // Next-state: advance the scoreboard, pick forwarding for the instruction
    // entering EX, count load-use stall cycles without wrapping.
    always_comb begin
        sb_d[SB_WB]  = sb_q[SB_MEM];
        sb_d[SB_MEM] = sb_q[SB_EX];
        sb_d[SB_EX]  = SB_EMPTY;
        if (!bubble) begin
            sb_d[SB_EX].valid   = hz.id_valid_i;
            sb_d[SB_EX].rd      = hz.id_rd_i;
            sb_d[SB_EX].we      = hz.id_rd_we_i;
            sb_d[SB_EX].is_load = hz.id_is_load_i;
        end

        fwd_rs1_d = FWD_RF;
        fwd_rs2_d = FWD_RF;
        if (!bubble) begin
            fwd_rs1_d = fwd_pick(hz.id_use_rs1_i, rs1_hit_ex, rs1_hit_mem);
            fwd_rs2_d = fwd_pick(hz.id_use_rs2_i, rs2_hit_ex, rs2_hit_mem);
        end

        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_q[i] <= SB_EMPTY;
            end
            fwd_rs1_q   <= FWD_RF;
            fwd_rs2_q   <= FWD_RF;
            stall_cnt_q <= '0;
        end else begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_q[i] <= sb_d[i];
            end
            fwd_rs1_q   <= fwd_rs1_d;
            fwd_rs2_q   <= fwd_rs2_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_if_o  = stall;
    assign hz.stall_id_o  = stall;
    assign hz.flush_if_o  = flush;
    assign hz.flush_id_o  = flush;
    assign hz.bubble_ex_o = bubble;
    assign hz.fwd_rs1_o   = fwd_rs1_q;
    assign hz.fwd_rs2_o   = fwd_rs2_q;
    assign hz.stall_cnt_o = stall_cnt_q;

endmodule
